// File: rtl/rd73_frame_acc.sv
// rd73_frame_acc -- frame accumulator placed directly after the rd73 7-input
// ones-counter.
//
// Each weight (0..7) accepted on the valid/ready input is added into a running
// frame sum. The block also tracks the frame maximum and compares the sum
// against a threshold. Every FRAME_LEN weights, one registered result is
// presented on the valid/ready output. The next frame accumulates while the
// consumer has not yet taken the previous result. If a frame completes while
// the previous result is still waiting, the block stalls its input until the
// consumer takes that result.
//
// Parameters:
//   FRAME_LEN  weights per frame (2..255)
//   ACC_W      width of the frame sum; 7*FRAME_LEN must fit in ACC_W bits
//   THRESH     out_over threshold (0..7*FRAME_LEN)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   clear      synchronous abort of the partial frame (outputs untouched)
//   in_valid   w_in carries a weight
//   in_ready   block accepts w_in this cycle (depends on state only)
//   w_in       3-bit weight from the ones-counter
//   out_valid  frame result valid
//   out_ready  consumer takes the result
//   out_sum    frame sum
//   out_max    largest weight in the frame
//   out_over   out_sum >= THRESH
//   frame_idx  number of frames delivered, wraps at 256
//   out_min    smallest weight in the frame (only with RD73_FRAME_MIN_EN)
//
// Optional feature macro: RD73_FRAME_MIN_EN adds frame-minimum tracking and
// the out_min port.
module rd73_frame_acc #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 7,
  parameter int THRESH    = 56
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       w_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [2:0]       out_max,
  output logic             out_over,
  output logic [7:0]       frame_idx
`ifdef RD73_FRAME_MIN_EN
  ,
  output logic [2:0]       out_min
`endif
);

  typedef enum logic {ACCUM, STALL} state_t;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // The threshold is applied to the complete frame sum, never to a partial acc.
  function automatic logic over_thr(input logic [ACC_W-1:0] s);
    return s >= ACC_W'(THRESH);
  endfunction

  state_t           state, state_nxt;

  logic [ACC_W-1:0] acc_p0;
  logic [2:0]       mx_p0;
  logic [7:0]       cnt_p0;

  logic [ACC_W-1:0] sum_p1;
  logic [2:0]       max_p1;
  logic             over_p1;
  logic             vld_p1;
  logic [7:0]       idx_p1;

  logic [ACC_W-1:0] sum_nxt;
  logic [2:0]       mx_nxt;
  logic             last;
  logic             out_xfer;

  // Control decodes produced by the FSM
  logic             step;     // fold a non-final sample and advance cnt
  logic             fold;     // fold the final sample and hold it (enter STALL)
  logic             wipe;     // return acc/mx/cnt to their empty-frame values
  logic             load_in;  // load outputs from acc + w_in (final sample)
  logic             load_acc; // load outputs from the completed acc (leaving STALL)

`ifdef RD73_FRAME_MIN_EN
  logic [2:0]       mn_p0;
  logic [2:0]       min_p1;
  logic [2:0]       mn_nxt;
  assign mn_nxt = min3(mn_p0, w_in);
`endif

  assign sum_nxt  = acc_p0 + ACC_W'(w_in);
  assign mx_nxt   = max3(mx_p0, w_in);
  assign last     = (cnt_p0 == LAST_CNT);
  assign out_xfer = vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // in_ready is decoded from the state alone, and it is also low during reset.
  // While in ACCUM, an input transfer is therefore just in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    step      = 1'b0;
    fold      = 1'b0;
    wipe      = 1'b0;
    load_in   = 1'b0;
    load_acc  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = rst_n;
        if (clear) begin
          wipe = 1'b1;
        end else if (in_valid) begin
          if (!last) begin
            step = 1'b1;
          end else if (!vld_p1 || out_ready) begin
            load_in = 1'b1;
            wipe    = 1'b1;
          end else begin
            fold      = 1'b1;
            state_nxt = STALL;
          end
        end
      end
      STALL: begin
        if (clear) begin
          wipe      = 1'b1;
          state_nxt = ACCUM;
        end else if (out_ready) begin
          load_acc  = 1'b1;
          wipe      = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // ---- stage p0: frame accumulation ----
  always_ff @(posedge clk) begin
    if (!rst_n || wipe) begin
      acc_p0 <= '0;
      mx_p0  <= '0;
      cnt_p0 <= '0;
    end else if (step || fold) begin
      acc_p0 <= sum_nxt;
      mx_p0  <= mx_nxt;
      // On the final sample cnt stays at FRAME_LEN-1 while the frame waits.
      if (step) cnt_p0 <= cnt_p0 + 8'd1;
    end
  end

`ifdef RD73_FRAME_MIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n || wipe)    mn_p0 <= 3'd7;
    else if (step || fold) mn_p0 <= mn_nxt;
  end
`endif

  // ---- stage p1: registered frame result ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      max_p1  <= '0;
      over_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      idx_p1  <= '0;
    end else begin
      if (load_in) begin
        sum_p1  <= sum_nxt;
        max_p1  <= mx_nxt;
        over_p1 <= over_thr(sum_nxt);
        vld_p1  <= 1'b1;
      end else if (load_acc) begin
        sum_p1  <= acc_p0;
        max_p1  <= mx_p0;
        over_p1 <= over_thr(acc_p0);
        vld_p1  <= 1'b1;
      end else if (out_xfer) begin
        vld_p1  <= 1'b0;
      end
      if (out_xfer) idx_p1 <= idx_p1 + 8'd1;
    end
  end

`ifdef RD73_FRAME_MIN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        min_p1 <= '0;
    else if (load_in)  min_p1 <= mn_nxt;
    else if (load_acc) min_p1 <= mn_p0;
  end
  assign out_min = min_p1;
`endif

  assign out_sum   = sum_p1;
  assign out_max   = max_p1;
  assign out_over  = over_p1;
  assign out_valid = vld_p1;
  assign frame_idx = idx_p1;

endmodule

// File: tb/tb_rd73_frame_acc.sv
// Scoreboard testbench for rd73_frame_acc.
//
// The driver issues directed and random traffic. The reference model observes
// the accepted weights, builds the frames as lists, and pushes each completed
// frame's expected result into a queue. The monitor checks the handshake and
// output registers every cycle, and it pops an entry whenever a result is
// handed to the consumer.
module tb_rd73_frame_acc;

  localparam int FRAME_LEN = 16;
  localparam int ACC_W     = 7;
  localparam int THRESH    = 56;

  typedef struct {
    int sum;
    int mx;
    int mn;
    int over;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       w_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [2:0]       out_max;
  logic             out_over;
  logic [7:0]       frame_idx;
`ifdef RD73_FRAME_MIN_EN
  logic [2:0]       out_min;
`endif

  rd73_frame_acc #(.FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_max(out_max), .out_over(out_over),
    .frame_idx(frame_idx)
`ifdef RD73_FRAME_MIN_EN
    , .out_min(out_min)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t exp_q[$];
  int   frame_w[$];
  res_t hold;
  int   delivered = 0;
  bit   stall_pre = 1'b0;
  int   or_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the checks run mid-cycle, when the inputs and outputs are stable
  // ahead of the next rising edge.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      chk("in_ready_in_reset", int'(in_ready), 0);
    end else begin
      e = (exp_q.size() > 0) ? exp_q[0] : hold;
      chk("in_ready", int'(in_ready), int'(exp_q.size() < 2));
      chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
      chk("out_sum", int'(out_sum), e.sum);
      chk("out_max", int'(out_max), e.mx);
      chk("out_over", int'(out_over), e.over);
`ifdef RD73_FRAME_MIN_EN
      chk("out_min", int'(out_min), e.mn);
`endif
      chk("frame_idx", int'(frame_idx), delivered % 256);
      stall_pre = (exp_q.size() == 2);
      if (exp_q.size() > 0 && out_ready) begin
        hold = exp_q.pop_front();
        delivered++;
      end
    end
  end

  // Reference model: it runs after the monitor in the same half-cycle. It
  // judges acceptance from the expected in_ready state (stall_pre), not from
  // the value the DUT reports.
  always @(negedge clk) begin
    res_t r;
    #1;
    if (!rst_n) begin
      frame_w.delete();
      exp_q.delete();
      hold = '{0, 0, 0, 0};
      delivered = 0;
    end else if (clear) begin
      frame_w.delete();
      if (stall_pre) void'(exp_q.pop_back());
    end else if (in_valid && !stall_pre) begin
      frame_w.push_back(int'(w_in));
      if (frame_w.size() == FRAME_LEN) begin
        r = '{0, 0, 7, 0};
        foreach (frame_w[i]) begin
          r.sum += frame_w[i];
          if (frame_w[i] > r.mx) r.mx = frame_w[i];
          if (frame_w[i] < r.mn) r.mn = frame_w[i];
        end
        r.over = int'(r.sum >= THRESH);
        exp_q.push_back(r);
        frame_w.delete();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (or_mode == 2) out_ready = ($urandom_range(0, 2) != 0);
    else              out_ready = (or_mode == 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Present one weight and hold it until it is accepted. The wait is bounded.
  task automatic send(input int w);
    bit ok;
    in_valid = 1'b1;
    w_in = 3'(w);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
      if (ok) return;
    end
    n_err++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles at %0t", $time);
  endtask

  initial begin
    hold = '{0, 0, 0, 0};
    repeat (2) cyc();
    rst_n = 1'b1;

    // Streaming at full rate: 0..7,0..7 gives sum 56 (at threshold).
    for (int i = 0; i < 16; i++) send(i % 8);
    // Below threshold, then above it, with no gap between the two frames.
    for (int i = 0; i < 16; i++) send(3);
    for (int i = 0; i < 16; i++) send(4);
    idle(3);

    // Backpressure across two frames. The second frame stalls the input.
    or_mode = 1;
    for (int i = 0; i < 16; i++) send(1);
    for (int i = 0; i < 16; i++) send(2);
    idle(4);
    or_mode = 0;
    idle(4);

    // A clear in mid-frame discards the partial frame and the sample in the
    // clear cycle. The previous result is not affected.
    or_mode = 1;
    for (int i = 0; i < 16; i++) send(5);
    for (int i = 0; i < 5; i++) send(7);
    clear = 1'b1; in_valid = 1'b1; w_in = 3'd7;
    cyc();
    clear = 1'b0;
    or_mode = 0;
    for (int i = 0; i < 16; i++) send(2);
    idle(3);

    // Reset in mid-frame while a result is still pending.
    or_mode = 1;
    for (int i = 0; i < 16; i++) send(6);
    for (int i = 0; i < 4; i++) send(7);
    rst_n = 1'b0; in_valid = 1'b1; w_in = 3'd7;
    cyc();
    rst_n = 1'b1;
    or_mode = 0;
    for (int i = 0; i < 16; i++) send(7);
    idle(3);

    // The minimum sits in the last sample: 15 x 6 followed by a 1.
    for (int i = 0; i < 15; i++) send(6);
    send(1);
    idle(3);

    // Random traffic with random consumer stalls and occasional clears.
    or_mode = 2;
    for (int c = 0; c < 900; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      w_in     = 3'($urandom_range(0, 7));
      clear    = ($urandom_range(0, 59) == 0);
      cyc();
    end
    clear = 1'b0;
    in_valid = 1'b0;
    or_mode = 0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
